stepper_pulse_generator: RTL and testbench
==========================================

// Module: stepper_pulse_generator
// PURPOSE
//   Consumer of the joint step commands (th1_steps/th2_steps) produced by scara_controller.
//   Accepts one signed step-delta pair per valid/ready handshake and drives STEP/DIR pins
//   for both joint stepper drivers.
//   Steps are emitted in lockstep ticks; both joints are tracked as absolute position counters.
//   Sits between the kinematics controller and the stepper driver pins.
// PARAMETERS
//   PULSE_CYCLES      50  clk cycles for STEP high phase; the low phase is equal (must be >=1)
//   DIR_SETUP_CYCLES  10  clk cycles DIR is held stable before the first STEP edge (>=1)
//   POS_W             16  width of signed position counters th1_pos/th2_pos
// PORTS
//   clk        in   1      system clock; all logic on posedge
//   reset      in   1      synchronous, active-high reset
//   cmd_valid  in   1      step-delta pair on th1_steps/th2_steps is valid
//   cmd_ready  out  1      block idle and able to accept a command
//   th1_steps  in   9      joint-1 step delta, two's complement (-256..255)
//   th2_steps  in   9      joint-2 step delta, two's complement
//   abort      in   1      stop the current move at the next safe point
//   step1      out  1      joint-1 STEP pin
//   dir1       out  1      joint-1 DIR pin: 1 = positive delta, 0 = negative delta
//   step2      out  1      joint-2 STEP pin
//   dir2       out  1      joint-2 DIR pin: 1 = positive delta, 0 = negative delta
//   busy       out  1      move in progress (every state except IDLE)
//   done       out  1      one-cycle pulse at end of every accepted command
//   aborted    out  1      valid with done: 1 = the move ended by abort
//   th1_pos    out  POS_W  signed absolute joint-1 step count
//   th2_pos    out  POS_W  signed absolute joint-2 step count
// BEHAVIOUR
//   - Reset (any cycle, including mid-move): state=IDLE; step*/dir*/busy/done/aborted=0;
//     pos=0; cmd_ready=1 in the first cycle after reset deasserts.
//   - All outputs are registered. cmd_ready=1 only in IDLE.
//   - States: IDLE, SETUP, STEP_HI, STEP_LO, DONE.
//   - Accept: cmd_valid&&cmd_ready at edge k. On that edge:
//       rem_n <= |thn_steps| (10-bit unsigned; -256 gives 256)
//       dir_n <= ~thn_steps[8]
//   - Zero command (both deltas 0): IDLE->DONE. done=1 in cycle k+1. No STEP activity.
//   - Otherwise IDLE->SETUP, held DIR_SETUP_CYCLES cycles, then ->STEP_HI.
//   - STEP_HI lasts PULSE_CYCLES cycles. step_n=1 iff rem_n>0 at STEP_HI entry.
//   - On the STEP_HI->STEP_LO edge, for each joint that pulsed:
//       rem_n -= 1; thn_pos += dir_n ? +1 : -1
//     pos arithmetic wraps modulo 2^POS_W.
//   - STEP_LO lasts PULSE_CYCLES cycles with both step_n=0.
//     At its end: ->DONE if both rem==0, else ->STEP_HI.
//   - n = max(|th1|,|th2|) > 0: first STEP rise in cycle k+1+D; done in cycle k+D+2*P*n+1
//     (D=DIR_SETUP_CYCLES, P=PULSE_CYCLES).
//   - DONE: exactly one cycle with done=1 and busy=1, then IDLE.
//     cmd_ready returns to 1 in the following cycle.
//   - dir_n changes only on the accept edge. It is never changed while step_n=1
//     or during SETUP/STEP_LO.
//   - abort, sampled each cycle while busy:
//       in SETUP   -> DONE next edge; no pulses.
//       in STEP_HI -> finish the high phase and the full low phase (the step is counted),
//                     then DONE.
//       in STEP_LO -> finish the low phase, then DONE.
//     aborted=1 with done. abort in IDLE or DONE is ignored.
//   - cmd_valid while busy is ignored (no handshake); the command is not queued.
// TESTING (P=2, D=1)
//   1. Assert reset 3 cycles mid-stimulus, release -> all outputs 0, pos=0, cmd_ready=1 next cycle.
//   2. th1=3, th2=-1 -> dir1=1, dir2=0; step1: 3 pulses (2 high/2 low); step2: 1 pulse;
//      done 14 cycles after accept; th1_pos=3, th2_pos=-1, aborted=0.
//   3. th1=0, th2=0 -> done 1 cycle after accept, no STEP edges, pos unchanged.
//   4. th1=-256, th2=255 -> 256 step1 / 255 step2 pulses; th1_pos=-256, th2_pos=255.
//      Also with POS_W=8 from pos=127: a +1 step wraps th1_pos to -128.
//   5. th1=5; abort during 2nd STEP_HI -> exactly 2 step1 pulses, done=1 with aborted=1,
//      th1_pos=2. cmd_valid pulsed while busy -> ignored.
//   6. Reset during STEP_HI of th1=4 -> step1=0 on the next cycle, pos=0, IDLE, no done pulse.

Source files
------------

// File: rtl/stepper_pulse_generator.sv
// Stepper STEP/DIR pulse generator for two joints driven in lockstep.
// Ports: clk, reset (sync, active high), cmd_valid/cmd_ready handshake,
//   th1_steps/th2_steps (signed 9-bit deltas), abort, step1/dir1,
//   step2/dir2, busy, done, aborted, th1_pos/th2_pos (absolute counts).
module stepper_pulse_generator #(
  parameter int PULSE_CYCLES     = 50,
  parameter int DIR_SETUP_CYCLES = 10,
  parameter int POS_W            = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [8:0]       th1_steps,
  input  logic [8:0]       th2_steps,
  input  logic             abort,
  output logic             step1,
  output logic             dir1,
  output logic             step2,
  output logic             dir2,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [POS_W-1:0] th1_pos,
  output logic [POS_W-1:0] th2_pos
);

  localparam int CMAX = (PULSE_CYCLES > DIR_SETUP_CYCLES) ?
                        PULSE_CYCLES : DIR_SETUP_CYCLES;
  localparam int CW = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_SETUP = CW'(DIR_SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_PULSE = CW'(PULSE_CYCLES - 1);
  localparam logic [POS_W-1:0] P_ONE = POS_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STEP_HI,
    S_STEP_LO,
    S_DONE
  } state_t;

  state_t      state;
  logic [CW-1:0] cnt;
  logic [9:0]  rem1;
  logic [9:0]  rem2;
  logic        abort_pend;

  // Magnitude of a 9-bit two's complement delta; -256 maps to 256.
  function automatic logic [9:0] mag(input logic [8:0] s);
    logic [9:0] ext;
    ext = {s[8], s};
    return s[8] ? (10'd0 - ext) : ext;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rem1       <= '0;
      rem2       <= '0;
      abort_pend <= 1'b0;
      step1      <= 1'b0;
      step2      <= 1'b0;
      dir1       <= 1'b0;
      dir2       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
      cmd_ready  <= 1'b1;
      th1_pos    <= '0;
      th2_pos    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            rem1       <= mag(th1_steps);
            rem2       <= mag(th2_steps);
            dir1       <= ~th1_steps[8];
            dir2       <= ~th2_steps[8];
            abort_pend <= 1'b0;
            cmd_ready  <= 1'b0;
            busy       <= 1'b1;
            if (th1_steps == 9'd0 && th2_steps == 9'd0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_SETUP;
              cnt   <= C_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (abort) begin
            state   <= S_DONE;
            done    <= 1'b1;
            aborted <= 1'b1;
          end else if (cnt == '0) begin
            state <= S_STEP_HI;
            step1 <= (rem1 != 10'd0);
            step2 <= (rem2 != 10'd0);
            cnt   <= C_PULSE;
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        S_STEP_HI: begin
          // An abort here still lets the current step complete.
          if (abort) abort_pend <= 1'b1;
          if (cnt == '0) begin
            state <= S_STEP_LO;
            step1 <= 1'b0;
            step2 <= 1'b0;
            cnt   <= C_PULSE;
            if (step1) begin
              rem1    <= rem1 - 10'd1;
              th1_pos <= dir1 ? th1_pos + P_ONE : th1_pos - P_ONE;
            end
            if (step2) begin
              rem2    <= rem2 - 10'd1;
              th2_pos <= dir2 ? th2_pos + P_ONE : th2_pos - P_ONE;
            end
          end else begin
            cnt <= cnt - C_ONE;
          end
        end
        S_STEP_LO: begin
          if (cnt == '0) begin
            if (abort || abort_pend ||
                (rem1 == 10'd0 && rem2 == 10'd0)) begin
              state   <= S_DONE;
              done    <= 1'b1;
              aborted <= abort || abort_pend;
            end else begin
              state <= S_STEP_HI;
              step1 <= (rem1 != 10'd0);
              step2 <= (rem2 != 10'd0);
              cnt   <= C_PULSE;
            end
          end else begin
            cnt <= cnt - C_ONE;
            if (abort) abort_pend <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          aborted   <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_pulse_generator.sv
// Randomized bench for stepper_pulse_generator against a timing/count model.
// Two instances (16-bit and 8-bit position) share the same stimulus.
module tb_stepper_pulse_generator;

  localparam int P = 2;
  localparam int D = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic [8:0] th1_steps;
  logic [8:0] th2_steps;
  logic       abort;

  logic        cmd_ready, step1, dir1, step2, dir2;
  logic        busy, done, aborted;
  logic [15:0] th1_pos, th2_pos;

  logic       cmd_ready8, step1_8, dir1_8, step2_8, dir2_8;
  logic       busy8, done8, aborted8;
  logic [7:0] th1_pos8, th2_pos8;

  int nchk = 0;
  int nerr = 0;
  int pos1 = 0;
  int pos2 = 0;

  always #5 clk = ~clk;

  stepper_pulse_generator #(
    .PULSE_CYCLES(P), .DIR_SETUP_CYCLES(D), .POS_W(16)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .th1_steps(th1_steps),
    .th2_steps(th2_steps), .abort(abort),
    .step1(step1), .dir1(dir1), .step2(step2), .dir2(dir2),
    .busy(busy), .done(done), .aborted(aborted),
    .th1_pos(th1_pos), .th2_pos(th2_pos)
  );

  stepper_pulse_generator #(
    .PULSE_CYCLES(P), .DIR_SETUP_CYCLES(D), .POS_W(8)
  ) dut8 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready8), .th1_steps(th1_steps),
    .th2_steps(th2_steps), .abort(abort),
    .step1(step1_8), .dir1(dir1_8), .step2(step2_8), .dir2(dir2_8),
    .busy(busy8), .done(done8), .aborted(aborted8),
    .th1_pos(th1_pos8), .th2_pos(th2_pos8)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_pos(input string tag);
    logic [15:0] e16;
    logic [7:0]  e8;
    e16 = pos1[15:0];
    check({tag, "_pos1"}, 32'(th1_pos), 32'(e16));
    e16 = pos2[15:0];
    check({tag, "_pos2"}, 32'(th2_pos), 32'(e16));
    e8 = pos1[7:0];
    check({tag, "_pos1_w8"}, 32'(th1_pos8), 32'(e8));
    e8 = pos2[7:0];
    check({tag, "_pos2_w8"}, 32'(th2_pos8), 32'(e8));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_outs"},
          32'({step1, dir1, step2, dir2, busy, done, aborted}), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check_pos(tag);
  endtask

  // One command: model computes end cycle, pulse counts, abort flag;
  // cycle j counts from 1 = first cycle after the accept edge.
  task automatic run_cmd(input int a, input int b,
                         input int abort_j, input int mid_j);
    logic [8:0] sa, sb;
    int n1, n2, n, ed, ep1, ep2, eab, i;
    int j, c1, c2, h1, h2, f1, f2, bad;
    logic pv1, pv2, dn;
    sa = 9'(a);
    sb = 9'(b);
    n1 = (a < 0) ? -a : a;
    n2 = (b < 0) ? -b : b;
    n = (n1 > n2) ? n1 : n2;
    if (n == 0) begin
      ed = 1; ep1 = 0; ep2 = 0; eab = 0;
    end else if (abort_j >= 1 && abort_j <= D) begin
      ed = abort_j + 1; ep1 = 0; ep2 = 0; eab = 1;
    end else if (abort_j > D && abort_j <= D + 2 * P * n) begin
      i = (abort_j - D - 1) / (2 * P);
      ed = D + 2 * P * (i + 1) + 1;
      ep1 = (n1 < i + 1) ? n1 : i + 1;
      ep2 = (n2 < i + 1) ? n2 : i + 1;
      eab = 1;
    end else begin
      ed = D + 2 * P * n + 1; ep1 = n1; ep2 = n2; eab = 0;
    end
    if (mid_j >= ed) mid_j = 0;

    j = 0;
    while (!cmd_ready && j < 10) begin
      @(negedge clk);
      j++;
    end
    check("ready_before", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    th1_steps = sa;
    th2_steps = sb;
    @(posedge clk);
    j = 0; c1 = 0; c2 = 0; h1 = 0; h2 = 0;
    f1 = 0; f2 = 0; bad = 0;
    pv1 = 1'b0; pv2 = 1'b0; dn = 1'b0;
    while (!dn && j < 4000) begin
      @(negedge clk);
      j++;
      cmd_valid = (j == mid_j);
      if (cmd_valid) begin
        th1_steps = 9'($urandom);
        th2_steps = 9'($urandom);
      end
      abort = (j == abort_j);
      if (step1 && !pv1) begin c1++; if (f1 == 0) f1 = j; end
      if (step2 && !pv2) begin c2++; if (f2 == 0) f2 = j; end
      if (step1) h1++;
      if (step2) h2++;
      pv1 = step1;
      pv2 = step2;
      if (dir1 !== ~sa[8] || dir2 !== ~sb[8]) bad++;
      if (done) begin
        dn = 1'b1;
        check("busy_at_done", 32'(busy), 32'd1);
        check("ready_at_done", 32'(cmd_ready), 32'd0);
        check("steps_at_done", 32'({step1, step2}), 32'd0);
      end
    end
    abort = 1'b0;
    cmd_valid = 1'b0;
    check("done_cycle", 32'(j), 32'(ed));
    check("aborted", 32'(aborted), 32'(eab));
    check("pulses1", 32'(c1), 32'(ep1));
    check("pulses2", 32'(c2), 32'(ep2));
    check("hi_cycles1", 32'(h1), 32'(P * ep1));
    check("hi_cycles2", 32'(h2), 32'(P * ep2));
    if (ep1 > 0) check("first_rise1", 32'(f1), 32'(D + 1));
    if (ep2 > 0) check("first_rise2", 32'(f2), 32'(D + 1));
    check("dir_stable", 32'(bad), 32'd0);
    pos1 += (a < 0) ? -ep1 : ep1;
    pos2 += (b < 0) ? -ep2 : ep2;
    check_pos("cmd");
    @(negedge clk);
    check("after_done",
          32'({done, busy, aborted, cmd_ready}), 32'b0001);
  endtask

  initial begin
    int a, b, aj, nn;
    logic gd;
    reset = 1'b1;
    cmd_valid = 1'b0;
    abort = 1'b0;
    th1_steps = '0;
    th2_steps = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("init");

    run_cmd(3, -1, 0, 3);
    run_cmd(0, 0, 0, 0);
    run_cmd(5, 0, D + 2 * P + 1, 2);
    run_cmd(-256, 255, 0, 7);

    // Reset in the second STEP_HI of a 4-step move, held 3 cycles.
    cmd_valid = 1'b1;
    th1_steps = 9'd4;
    th2_steps = 9'd0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (D + 2 * P) @(negedge clk);
    check("pre_reset_step1", 32'(step1), 32'd1);
    reset = 1'b1;
    pos1 = 0;
    pos2 = 0;
    gd = 1'b0;
    @(negedge clk);
    check("rst_step1", 32'(step1), 32'd0);
    check_pos("rst");
    if (done) gd = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) gd = 1'b1;
    end
    reset = 1'b0;
    @(negedge clk);
    if (done) gd = 1'b1;
    check("rst_no_done", 32'(gd), 32'd0);
    check_reset_state("rst_rel");

    run_cmd(127, 0, 0, 0);
    run_cmd(1, 0, 0, 0);
    check("wrap_w8", 32'(th1_pos8), 32'h80);

    for (int k = 0; k < 24; k++) begin
      a = int'($urandom_range(0, 24)) - 12;
      b = int'($urandom_range(0, 24)) - 12;
      nn = (a < 0) ? -a : a;
      if (((b < 0) ? -b : b) > nn) nn = (b < 0) ? -b : b;
      if ($urandom_range(0, 1) == 0) aj = 0;
      else aj = int'($urandom_range(1, D + 2 * P * nn + 2));
      run_cmd(a, b, aj, int'($urandom_range(0, 6)));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
